// File: rtl/mul_pkg.sv
// Shared definitions for the iterative mantissa multiplier: state encoding,
// default sizing and the derived iteration/counter widths.
package mul_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int BPC_DEF    = 4;
    localparam int PROD_W     = 2 * MANT_W_DEF;
    localparam int N_ITER     = MANT_W_DEF / BPC_DEF;
    localparam int CNT_W      = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for an arbitrary iteration count; never narrower than one bit.
    function automatic int cnt_width(input int n_iter);
        return (n_iter > 1) ? $clog2(n_iter) : 1;
    endfunction

endpackage

// File: rtl/mul_mod_iter_if.sv
// Operand/product handshake bundle for mul_mod_iter.
// Carries the Norm_shift/Mantissa_N/Sticky signals only when MUL_MOD_NORM_EN is defined.
interface mul_mod_iter_if
    import mul_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic [MANT_W-1:0]     Mantissa_A;
    logic [MANT_W-1:0]     Mantissa_B;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*MANT_W-1:0]   Producto;
`ifdef MUL_MOD_NORM_EN
    logic                  Norm_shift;
    logic [MANT_W-1:0]     Mantissa_N;
    logic                  Sticky;
`endif

    modport slave (
        input  in_valid, Mantissa_A, Mantissa_B, out_ready,
        output in_ready, out_valid, Producto
`ifdef MUL_MOD_NORM_EN
        , output Norm_shift, Mantissa_N, Sticky
`endif
    );

    modport master (
        output in_valid, Mantissa_A, Mantissa_B, out_ready,
        input  in_ready, out_valid, Producto
`ifdef MUL_MOD_NORM_EN
        , input Norm_shift, Mantissa_N, Sticky
`endif
    );

endinterface

// File: rtl/mul_pp_slice.sv
// Combinational MANT_W x BITS_PER_CYCLE partial product: one shifted copy of
// the multiplicand per multiplier bit, summed.
module mul_pp_slice #(
    parameter int MANT_W         = 24,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [MANT_W-1:0]                a,
    input  logic [BITS_PER_CYCLE-1:0]        b,
    output logic [MANT_W+BITS_PER_CYCLE-1:0] pp
);
    localparam int PP_W = MANT_W + BITS_PER_CYCLE;

    logic [PP_W-1:0] term [BITS_PER_CYCLE];

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
            assign term[gi] = b[gi] ? (PP_W'(a) << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pp = pp + term[i];
        end
    end

endmodule

// File: rtl/mul_mod_iter.sv
// Iterative shift-add mantissa multiplier with valid/ready handshakes and a
// zero-operand fast path. Optional normalisation outputs under MUL_MOD_NORM_EN.
module mul_mod_iter
    import mul_pkg::*;
#(
    parameter int MANT_W         = MANT_W_DEF,
    parameter int BITS_PER_CYCLE = BPC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mul_mod_iter_if.slave bus,
    output logic          busy
);
    localparam int ACC_W = 2 * MANT_W;
    localparam int ITERS = MANT_W / BITS_PER_CYCLE;
    localparam int CW    = cnt_width(ITERS);
    localparam int PP_W  = MANT_W + BITS_PER_CYCLE;

    generate
        if (MANT_W % BITS_PER_CYCLE != 0) begin : g_bad_cfg
            $error("mul_mod_iter: BITS_PER_CYCLE must divide MANT_W");
        end
    endgenerate

    state_t            state_reg;
    logic [MANT_W-1:0] a_reg;
    logic [MANT_W-1:0] b_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  addend;
    logic [CW-1:0]     cnt_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              busy_reg;
    logic [PP_W-1:0]   pp;

    mul_pp_slice #(
        .MANT_W         (MANT_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp_slice (
        .a  (a_reg),
        .b  (b_reg[BITS_PER_CYCLE-1:0]),
        .pp (pp)
    );

    // acc_next is shared with the optional normalisation registers so they
    // settle on the same edge that raises out_valid.
    always_comb begin
        addend   = ACC_W'(pp) << (BITS_PER_CYCLE * int'(cnt_reg));
        acc_next = acc_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) acc_next = '0;
            CALC:    acc_next = acc_reg + addend;
            default: acc_next = acc_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.Mantissa_A;
                        b_reg        <= bus.Mantissa_B;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (bus.Mantissa_A == '0 || bus.Mantissa_B == '0) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    b_reg   <= b_reg >> BITS_PER_CYCLE;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(ITERS - 1)) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.Producto  = acc_reg;
    assign busy          = busy_reg;

`ifdef MUL_MOD_NORM_EN
    logic              norm_shift_reg;
    logic [MANT_W-1:0] mant_n_reg;
    logic              sticky_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_shift_reg <= 1'b0;
            mant_n_reg     <= '0;
            sticky_reg     <= 1'b0;
        end else begin
            norm_shift_reg <= acc_next[ACC_W-1];
            if (acc_next[ACC_W-1]) begin
                mant_n_reg <= acc_next[ACC_W-1:MANT_W];
                sticky_reg <= |acc_next[MANT_W-1:0];
            end else begin
                mant_n_reg <= acc_next[ACC_W-2:MANT_W-1];
                sticky_reg <= |acc_next[MANT_W-2:0];
            end
        end
    end

    assign bus.Norm_shift = norm_shift_reg;
    assign bus.Mantissa_N = mant_n_reg;
    assign bus.Sticky     = sticky_reg;
`endif

endmodule

// File: tb/tb_mul_mod_iter.sv
// Directed self-checking bench for mul_mod_iter (default 24-bit, 4 bits/cycle).
// Inputs change and outputs are sampled just after the falling edge.
module tb_mul_mod_iter;

    logic clk;
    logic rst;
    logic busy;
    int   checks = 0;
    int   passes = 0;

    mul_mod_iter_if #(.MANT_W(24)) bus ();

    mul_mod_iter #(
        .MANT_W         (24),
        .BITS_PER_CYCLE (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [23:0] a, input logic [23:0] b);
        bus.Mantissa_A = a;
        bus.Mantissa_B = b;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // lat = number of rising edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.Mantissa_A = '0;
        bus.Mantissa_B = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (bus.Producto !== 48'h0) $display("FAIL reset_producto: got %h expected 0", bus.Producto); else passes++;
`ifdef MUL_MOD_NORM_EN
        checks++; if ({bus.Norm_shift, bus.Mantissa_N, bus.Sticky} !== 26'h0) $display("FAIL reset_norm: got %h expected 0", {bus.Norm_shift, bus.Mantissa_N, bus.Sticky}); else passes++;
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); else passes++;
    endtask

    task automatic test_basic();
        logic [23:0] va [3];
        logic [23:0] vb [3];
        logic [47:0] ve [3];
        logic [23:0] vm [3];
        logic        vn [3];
        logic        vs [3];
        int lat;
        va = '{24'h800000, 24'hC00000, 24'hFFFFFF};
        vb = '{24'h800000, 24'hC00000, 24'hFFFFFF};
        ve = '{48'h400000000000, 48'h900000000000, 48'hFFFFFE000001};
        vm = '{24'h800000, 24'h900000, 24'hFFFFFE};
        vn = '{1'b0, 1'b1, 1'b1};
        vs = '{1'b0, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i]);
            wait_valid(lat);
            checks++; if (lat != 6) $display("FAIL basic%0d_latency: got %0d expected 6", i, lat); else passes++;
            checks++; if (bus.Producto !== ve[i]) $display("FAIL basic%0d_producto: got %h expected %h", i, bus.Producto, ve[i]); else passes++;
            checks++; if (busy !== 1'b1) $display("FAIL basic%0d_busy: got %b expected 1", i, busy); else passes++;
`ifdef MUL_MOD_NORM_EN
            checks++; if (bus.Norm_shift !== vn[i]) $display("FAIL basic%0d_norm_shift: got %b expected %b", i, bus.Norm_shift, vn[i]); else passes++;
            checks++; if (bus.Mantissa_N !== vm[i]) $display("FAIL basic%0d_mantissa_n: got %h expected %h", i, bus.Mantissa_N, vm[i]); else passes++;
            checks++; if (bus.Sticky !== vs[i]) $display("FAIL basic%0d_sticky: got %b expected %b", i, bus.Sticky, vs[i]); else passes++;
`endif
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL basic%0d_release: got valid=%b ready=%b expected valid=0 ready=1", i, bus.out_valid, bus.in_ready); else passes++;
            $display("basic op %0d: %h * %h -> %h latency %0d", i, va[i], vb[i], ve[i], lat);
        end
    endtask

    task automatic test_zero_fast_path();
        int lat;
        bus.out_ready = 1'b0;
        issue(24'h000000, 24'hABCDEF);
        wait_valid(lat);
        checks++; if (lat != 0) $display("FAIL zero_latency: got %0d expected 0 edges after accept", lat); else passes++;
        checks++; if (bus.Producto !== 48'h0) $display("FAIL zero_producto: got %h expected 0", bus.Producto); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL zero_in_ready: got %b expected 0", bus.in_ready); else passes++;
        // A request offered during DONE must not be taken.
        bus.Mantissa_A = 24'h000005;
        bus.Mantissa_B = 24'h000007;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.Producto !== 48'h0) $display("FAIL zero_ignore_in_valid: got valid=%b prod=%h expected valid=1 prod=0", bus.out_valid, bus.Producto); else passes++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL zero_release: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); else passes++;
        repeat (8) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL zero_no_phantom: got valid=%b busy=%b expected 0 0", bus.out_valid, busy); else passes++;
        $display("zero op: 000000 * abcdef -> 0 latency %0d", lat);
    endtask

    task automatic test_backpressure();
        int   lat;
        logic ready_seen;
        bus.out_ready = 1'b0;
        issue(24'h800001, 24'h000003);
        lat = 0;
        ready_seen = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 6) $display("FAIL bp_latency: got %0d expected 6", lat); else passes++;
        for (int k = 0; k < 6; k++) begin
            if (bus.in_ready) ready_seen = 1'b1;
            checks++; if (bus.out_valid !== 1'b1 || bus.Producto !== 48'h000001800003) $display("FAIL bp_hold%0d: got valid=%b prod=%h expected valid=1 prod=000001800003", k, bus.out_valid, bus.Producto); else passes++;
            if (k == 5) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        checks++; if (ready_seen !== 1'b0) $display("FAIL bp_in_ready_busy: got in_ready high during op, expected 0"); else passes++;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); else passes++;
        $display("backpressure op: 800001 * 000003 -> 000001800003 latency %0d", lat);
    endtask

    task automatic test_back_to_back();
        logic [23:0] va [2];
        logic [23:0] vb [2];
        logic [47:0] ve [2];
        int lat;
        va = '{24'h123456, 24'h000001};
        vb = '{24'h000010, 24'hFFFFFF};
        ve = '{48'h000001234560, 48'h000000FFFFFF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(va[i], vb[i]);
            wait_valid(lat);
            checks++; if (bus.Producto !== ve[i]) $display("FAIL b2b%0d_producto: got %h expected %h", i, bus.Producto, ve[i]); else passes++;
            @(negedge clk);
            $display("back-to-back op %0d: %h * %h -> %h latency %0d", i, va[i], vb[i], ve[i], lat);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        bus.out_ready = 1'b1;
        issue(24'hFFFFFF, 24'hFFFFFF);
        repeat (2) @(negedge clk);
        checks++; if (bus.Producto === 48'h0 || busy !== 1'b1) $display("FAIL midrst_inflight: got prod=%h busy=%b expected nonzero prod, busy=1", bus.Producto, busy); else passes++;
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_async_ctrl: got valid=%b busy=%b expected 0 0", bus.out_valid, busy); else passes++;
        checks++; if (bus.Producto !== 48'h0) $display("FAIL midrst_async_producto: got %h expected 0", bus.Producto); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_async_in_ready: got %b expected 1", bus.in_ready); else passes++;
        // in_valid held across reset: nothing accepted until reset is released.
        bus.Mantissa_A = 24'h800000;
        bus.Mantissa_B = 24'h800000;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL midrst_accept_in_reset: got busy=%b expected 0", busy); else passes++;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL midrst_first_accept: got busy=%b expected 1", busy); else passes++;
        wait_valid(lat);
        checks++; if (lat != 6) $display("FAIL midrst_latency: got %0d expected 6", lat); else passes++;
        checks++; if (bus.Producto !== 48'h400000000000) $display("FAIL midrst_producto: got %h expected 400000000000", bus.Producto); else passes++;
        @(negedge clk);
        $display("post-reset op: 800000 * 800000 -> 400000000000 latency %0d", lat);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_zero_fast_path();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
